// File: rtl/intra4_pred_sched_pkg.sv
// intra4_pred_sched_pkg: 4x4 intra mode codes, scheduler states, sub-block count and mode-mask helpers.
`default_nettype none

package intra4_pred_sched_pkg;

  localparam int NUM_SUBBLK = 16;
  localparam logic [4:0] NO_MODE = 5'd16;

  typedef enum logic [3:0] {
    DC4 = 4'd0, TM4 = 4'd1, VE4 = 4'd2, HE4 = 4'd3, LD4 = 4'd4,
    RD4 = 4'd5, VR4 = 4'd6, VL4 = 4'd7, HD4 = 4'd8, HU4 = 4'd9
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_RECON = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  // Lowest enabled mode at or above 'from'; NO_MODE when none remains.
  function automatic logic [4:0] first_mode_at(input logic [15:0] mask, input logic [4:0] from);
    logic [4:0] r;
    r = NO_MODE;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) r = 5'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] highest_mode(input logic [15:0] mask);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/intra4_nbr_buf.sv
// intra4_nbr_buf: neighbour storage for the 4x4 scan, recon write-back and (row,col) neighbour select.
`default_nettype none

module intra4_nbr_buf #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic                   upd,
  input  logic [3:0]             blk,
  input  logic [20*BIT_WIDTH-1:0] mb_top,
  input  logic [16*BIT_WIDTH-1:0] mb_left,
  input  logic [BIT_WIDTH-1:0]   mb_top_left,
  input  logic [16*BIT_WIDTH-1:0] recon_blk,
  output logic [4*BIT_WIDTH-1:0] nb_top,
  output logic [4*BIT_WIDTH-1:0] nb_top_right,
  output logic [4*BIT_WIDTH-1:0] nb_left,
  output logic [BIT_WIDTH-1:0]   nb_top_left
);

  localparam int BW = BIT_WIDTH;

  logic [BW-1:0] top_row  [16];
  logic [BW-1:0] top_ext  [4];
  logic [BW-1:0] left_in  [16];
  logic [BW-1:0] left_cur [4];
  logic [BW-1:0] corner;
  logic [BW-1:0] tl_in;

  logic [1:0] row;
  logic [1:0] col;
  assign row = blk[3:2];
  assign col = blk[1:0];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        top_row[i] <= mb_top[BW*i +: BW];
        left_in[i] <= mb_left[BW*i +: BW];
      end
      for (int k = 0; k < 4; k++) top_ext[k] <= mb_top[BW*(16+k) +: BW];
      tl_in <= mb_top_left;
    end else if (upd) begin
      // Capture the pixel above-right of this block before its column is overwritten.
      corner <= top_row[{col, 2'd3}];
      for (int k = 0; k < 4; k++) begin
        top_row[{col, 2'(k)}] <= recon_blk[BW*(12+k) +: BW];
        left_cur[k]           <= recon_blk[BW*(4*k+3) +: BW];
      end
    end
  end

  always_comb begin
    nb_top       = '0;
    nb_top_right = '0;
    nb_left      = '0;
    for (int k = 0; k < 4; k++) begin
      nb_top[BW*k +: BW]       = top_row[{col, 2'(k)}];
      nb_top_right[BW*k +: BW] = (col == 2'd3) ? top_ext[k] : top_row[{col + 2'd1, 2'(k)}];
      nb_left[BW*k +: BW]      = (col == 2'd0) ? left_in[{row, 2'(k)}] : left_cur[k];
    end
    if (col != 2'd0)      nb_top_left = corner;
    else if (row == 2'd0) nb_top_left = tl_in;
    else                  nb_top_left = left_in[{row, 2'd0} - 4'd1];
  end

endmodule

`default_nettype wire

// File: rtl/intra4_pred_sched.sv
// intra4_pred_sched: issues 4x4 intra prediction requests over a 16x16 MB in raster order.
// Optional INTRA4_MODE_MASK_EN adds a per-MB mode_mask selecting which modes are issued.
`default_nettype none

module intra4_pred_sched
  import intra4_pred_sched_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_MODES  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mb_start,
`ifdef INTRA4_MODE_MASK_EN
  input  logic [NUM_MODES-1:0]            mode_mask,
`endif
  input  logic [20*BIT_WIDTH-1:0]         mb_top,
  input  logic [16*BIT_WIDTH-1:0]         mb_left,
  input  logic [BIT_WIDTH-1:0]            mb_top_left,
  output logic                            mb_busy,
  output logic                            mb_done,
  output logic                            pred_valid,
  input  logic                            pred_ready,
  output logic [3:0]                      pred_blk,
  output logic [3:0]                      pred_mode,
  output logic                            pred_last,
  output logic [BLOCK_SIZE*BIT_WIDTH-1:0] pred_top,
  output logic [BLOCK_SIZE*BIT_WIDTH-1:0] pred_top_right,
  output logic [BLOCK_SIZE*BIT_WIDTH-1:0] pred_left,
  output logic [BIT_WIDTH-1:0]            pred_top_left,
  input  logic                            recon_valid,
  output logic                            recon_ready,
  input  logic [16*BIT_WIDTH-1:0]         recon_blk
);

  localparam logic [15:0] FULL_MASK = 16'((32'd1 << NUM_MODES) - 32'd1);

  state_t      state;
  logic [15:0] start_mask;
  logic [15:0] cur_mask;

`ifdef INTRA4_MODE_MASK_EN
  logic [15:0] mask_q;
  always_ff @(posedge clk) begin
    if (rst)                                mask_q <= '0;
    else if (state == ST_IDLE && mb_start)  mask_q <= 16'(mode_mask);
  end
  assign start_mask = 16'(mode_mask);
  assign cur_mask   = mask_q;
`else
  assign start_mask = FULL_MASK;
  assign cur_mask   = FULL_MASK;
`endif

  logic [4:0] first_start, first_cur, next_mode;
  logic [3:0] last_start, last_cur;
  assign first_start = first_mode_at(start_mask, 5'd0);
  assign first_cur   = first_mode_at(cur_mask, 5'd0);
  assign next_mode   = first_mode_at(cur_mask, {1'b0, pred_mode} + 5'd1);
  assign last_start  = highest_mode(start_mask);
  assign last_cur    = highest_mode(cur_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pred_blk    <= 4'd0;
      pred_mode   <= 4'd0;
      pred_valid  <= 1'b0;
      pred_last   <= 1'b0;
      recon_ready <= 1'b0;
      mb_busy     <= 1'b0;
      mb_done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (mb_start) begin
          state      <= ST_ISSUE;
          mb_busy    <= 1'b1;
          pred_blk   <= 4'd0;
          pred_mode  <= first_start[3:0];
          pred_valid <= (first_start != NO_MODE);
          pred_last  <= (first_start != NO_MODE) && (first_start[3:0] == last_start);
        end
        ST_ISSUE: begin
          // An empty mask leaves pred_valid low; go straight to reconstruction.
          if (!pred_valid) begin
            state       <= ST_WAIT_RECON;
            recon_ready <= 1'b1;
          end else if (pred_ready) begin
            if (next_mode == NO_MODE) begin
              state       <= ST_WAIT_RECON;
              pred_valid  <= 1'b0;
              pred_last   <= 1'b0;
              recon_ready <= 1'b1;
            end else begin
              pred_mode <= next_mode[3:0];
              pred_last <= (next_mode[3:0] == last_cur);
            end
          end
        end
        ST_WAIT_RECON: if (recon_valid) begin
          recon_ready <= 1'b0;
          if (pred_blk == 4'(NUM_SUBBLK - 1)) begin
            state   <= ST_DONE;
            mb_done <= 1'b1;
          end else begin
            state      <= ST_ISSUE;
            pred_blk   <= pred_blk + 4'd1;
            pred_mode  <= first_cur[3:0];
            pred_valid <= (first_cur != NO_MODE);
            pred_last  <= (first_cur != NO_MODE) && (first_cur[3:0] == last_cur);
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          mb_done <= 1'b0;
          mb_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [4*BIT_WIDTH-1:0] nb_top, nb_top_right, nb_left;
  logic [BIT_WIDTH-1:0]   nb_top_left;

  intra4_nbr_buf #(.BIT_WIDTH(BIT_WIDTH)) u_nbr_buf (
    .clk          (clk),
    .load         (state == ST_IDLE && mb_start),
    .upd          (state == ST_WAIT_RECON && recon_valid),
    .blk          (pred_blk),
    .mb_top       (mb_top),
    .mb_left      (mb_left),
    .mb_top_left  (mb_top_left),
    .recon_blk    (recon_blk),
    .nb_top       (nb_top),
    .nb_top_right (nb_top_right),
    .nb_left      (nb_left),
    .nb_top_left  (nb_top_left)
  );

  // Neighbour regs are not reset, so the bus reads zero whenever no request is offered.
  assign pred_top       = pred_valid ? nb_top       : '0;
  assign pred_top_right = pred_valid ? nb_top_right : '0;
  assign pred_left      = pred_valid ? nb_left      : '0;
  assign pred_top_left  = pred_valid ? nb_top_left  : '0;

endmodule

`default_nettype wire

// File: tb/tb_intra4_pred_sched.sv
// tb_intra4_pred_sched: randomized self-checking bench against a pixel-picture reference model.
`default_nettype none

module tb_intra4_pred_sched;

  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mb_start, pred_ready, recon_valid;
  logic [20*BW-1:0] mb_top;
  logic [16*BW-1:0] mb_left, recon_blk;
  logic [BW-1:0]  mb_top_left;
  logic           mb_busy, mb_done, pred_valid, pred_last, recon_ready;
  logic [3:0]     pred_blk, pred_mode;
  logic [4*BW-1:0] pred_top, pred_top_right, pred_left;
  logic [BW-1:0]  pred_top_left;
`ifdef INTRA4_MODE_MASK_EN
  logic [9:0]     mode_mask = '1;
`endif

  intra4_pred_sched dut (
    .clk(clk), .rst(rst), .mb_start(mb_start),
`ifdef INTRA4_MODE_MASK_EN
    .mode_mask(mode_mask),
`endif
    .mb_top(mb_top), .mb_left(mb_left), .mb_top_left(mb_top_left),
    .mb_busy(mb_busy), .mb_done(mb_done),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_blk(pred_blk),
    .pred_mode(pred_mode), .pred_last(pred_last), .pred_top(pred_top),
    .pred_top_right(pred_top_right), .pred_left(pred_left), .pred_top_left(pred_top_left),
    .recon_valid(recon_valid), .recon_ready(recon_ready), .recon_blk(recon_blk)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference picture: row -1 is the above row (with corner at x=-1), column -1 is the left column.
  logic [7:0] top_px [20];
  logic [7:0] left_px [16];
  logic [7:0] tl_px;
  logic [7:0] pic [16][16];

  function automatic logic [7:0] px(input int y, input int x);
    if (y < 0) return (x < 0) ? tl_px : top_px[x];
    if (x < 0) return left_px[y];
    return pic[y][x];
  endfunction

  task automatic exp_nbr(input int b, output logic [31:0] t, output logic [31:0] tr,
                         output logic [31:0] l, output logic [7:0] tlv);
    int r, c;
    r = b / 4;
    c = b % 4;
    for (int k = 0; k < 4; k++) begin
      t[8*k +: 8]  = px(4*r - 1, 4*c + k);
      tr[8*k +: 8] = (c == 3) ? top_px[16 + k] : px(4*r - 1, 4*c + 4 + k);
      l[8*k +: 8]  = px(4*r + k, 4*c - 1);
    end
    tlv = px(4*r - 1, 4*c - 1);
  endtask

  task automatic run_mb(input int ready_pct, input int recon_pct, input bit noise,
                        input bit fixed, input int abort_blk);
    int exp_blk, exp_mode, phase, ph, hs, cycles, r, c;
    bit stalled, done_due, finished;
    logic [31:0] e_t, e_tr, e_l, s_t, s_tr, s_l;
    logic [7:0]  e_tl, s_tl;
    logic [3:0]  s_blk, s_mode;
    logic        s_last;

    for (int i = 0; i < 20; i++) top_px[i] = fixed ? 8'(i) : 8'($urandom);
    for (int j = 0; j < 16; j++) left_px[j] = fixed ? 8'(8'h40 + j) : 8'($urandom);
    tl_px = fixed ? 8'hFF : 8'($urandom);
    for (int i = 0; i < 20; i++) mb_top[8*i +: 8] = top_px[i];
    for (int j = 0; j < 16; j++) mb_left[8*j +: 8] = left_px[j];
    mb_top_left = tl_px;

    mb_start = 1'b1;
    @(posedge clk); #1;
    mb_start = 1'b0;
    mb_top      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    mb_left     = {$urandom, $urandom, $urandom, $urandom};
    mb_top_left = 8'($urandom);
    check_val("start_pred_valid", pred_valid, 1);

    exp_blk = 0; exp_mode = 0; phase = 0; hs = 0; cycles = 0;
    stalled = 0; done_due = 0; finished = 0;
    s_t = '0; s_tr = '0; s_l = '0; s_tl = '0; s_blk = '0; s_mode = '0; s_last = 1'b0;

    while (!finished) begin
      if (cycles > 4000) begin
        check_val("timeout_cycles", 64'(cycles), 0);
        break;
      end
      if (abort_blk >= 0 && phase == 0 && exp_blk == abort_blk && exp_mode == 3) begin
        check_val("abort_point_valid", pred_valid, 1);
        rst = 1'b1; pred_ready = 1'b0; recon_valid = 1'b0; mb_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_pred_valid", pred_valid, 0);
        check_val("abort_recon_ready", recon_ready, 0);
        check_val("abort_busy", mb_busy, 0);
        check_val("abort_done", mb_done, 0);
        @(posedge clk); #1;
        check_val("abort_idle_busy", mb_busy, 0);
        check_val("abort_idle_done", mb_done, 0);
        return;
      end
      check_val("busy", mb_busy, 1);
      check_val("done", mb_done, 64'(done_due));
      if (done_due) begin
        check_val("handshakes_total", 64'(hs), 160);
        pred_ready = 1'b0; recon_valid = 1'b0;
        mb_start = noise;
        @(posedge clk); #1;
        mb_start = 1'b0;
        check_val("post_done_busy", mb_busy, 0);
        check_val("post_done_done", mb_done, 0);
        check_val("post_done_valid", pred_valid, 0);
        finished = 1;
      end else begin
        ph = phase;
        check_val("pred_valid_phase", pred_valid, 64'(ph == 0));
        check_val("recon_ready_phase", recon_ready, 64'(ph == 1));
        if (ph == 1) begin
          recon_valid = ($urandom_range(0, 99) < recon_pct);
          if (fixed) recon_blk = {16{8'(8'h80 + exp_blk)}};
          else       recon_blk = {$urandom, $urandom, $urandom, $urandom};
          if (recon_valid) begin
            r = exp_blk / 4;
            c = exp_blk % 4;
            for (int y = 0; y < 4; y++)
              for (int x = 0; x < 4; x++)
                pic[4*r + y][4*c + x] = recon_blk[8*(4*y + x) +: 8];
            exp_blk++;
            phase = 0;
            if (exp_blk == 16) done_due = 1;
          end
        end else begin
          recon_valid = noise && ($urandom_range(0, 3) == 0);
          recon_blk   = {$urandom, $urandom, $urandom, $urandom};
        end
        if (ph == 0 && pred_valid) begin
          exp_nbr(exp_blk, e_t, e_tr, e_l, e_tl);
          if (stalled) begin
            check_val("stall_blk", pred_blk, s_blk);
            check_val("stall_mode", pred_mode, s_mode);
            check_val("stall_last", pred_last, s_last);
            check_val("stall_top", pred_top, s_t);
            check_val("stall_top_right", pred_top_right, s_tr);
            check_val("stall_left", pred_left, s_l);
            check_val("stall_top_left", pred_top_left, s_tl);
          end
          check_val("pred_blk", pred_blk, 64'(exp_blk));
          check_val("pred_mode", pred_mode, 64'(exp_mode));
          check_val("pred_last", pred_last, 64'(exp_mode == 9));
          check_val("nbr_top", pred_top, e_t);
          check_val("nbr_top_right", pred_top_right, e_tr);
          check_val("nbr_left", pred_left, e_l);
          check_val("nbr_top_left", pred_top_left, e_tl);
          if (fixed && exp_blk == 5) begin
            check_val("t2_blk5_top", pred_top, 32'h81818181);
            check_val("t2_blk5_top_right", pred_top_right, 32'h82828282);
            check_val("t2_blk5_left", pred_left, 32'h84848484);
            check_val("t2_blk5_top_left", pred_top_left, 8'h80);
          end
          if (fixed && exp_blk == 7)
            check_val("t2_blk7_top_right", pred_top_right, 32'h13121110);
          s_blk = pred_blk; s_mode = pred_mode; s_last = pred_last;
          s_t = pred_top; s_tr = pred_top_right; s_l = pred_left; s_tl = pred_top_left;
          pred_ready = ($urandom_range(0, 99) < ready_pct);
          if (pred_ready) begin
            hs++;
            stalled = 0;
            if (exp_mode == 9) begin
              exp_mode = 0;
              phase = 1;
            end else begin
              exp_mode++;
            end
          end else begin
            stalled = 1;
          end
        end else begin
          pred_ready = 1'($urandom_range(0, 1));
        end
        mb_start = noise && ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        cycles++;
      end
    end
    mb_start = 1'b0; recon_valid = 1'b0; pred_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mb_start = 1'b0; pred_ready = 1'b0; recon_valid = 1'b0;
    mb_top = '0; mb_left = '0; mb_top_left = '0; recon_blk = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pred_valid", pred_valid, 0);
    check_val("rst_recon_ready", recon_ready, 0);
    check_val("rst_busy", mb_busy, 0);
    check_val("rst_done", mb_done, 0);
    check_val("rst_blk", pred_blk, 0);
    check_val("rst_mode", pred_mode, 0);
    check_val("rst_last", pred_last, 0);
    check_val("rst_top", pred_top, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_busy", mb_busy, 0);

    run_mb(100, 100, 1'b0, 1'b1, -1);  // full-rate MB with the fixed pixel pattern
    run_mb(50, 40, 1'b1, 1'b0, -1);    // random stalls, stray recon_valid and mb_start
    run_mb(70, 60, 1'b0, 1'b0, 6);     // reset mid-MB at blk 6 mode 3
    run_mb(80, 70, 1'b1, 1'b0, -1);    // restart after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
